// File: rtl/tree_lane_scheduler_pkg.sv
// Shared types and defaults for the two-lane decision-tree lookup pipeline.
// Widths here are also used by the level pipeline registers.
package tree_lane_scheduler_pkg;

  localparam int PACKET_WIDTH_DEF = 104;
  localparam int NODE_WIDTH_DEF   = 40;

  typedef enum logic [1:0] {
    SCH_RUN    = 2'd0,
    SCH_DRAIN  = 2'd1,
    SCH_UPDATE = 2'd2
  } sch_state_t;

  function automatic logic [1:0] count2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/tree_lane_scheduler_if.sv
// Ingress, lane-issue, completion and reconfiguration signals of the scheduler.
// The scheduler uses the slave side; the surrounding pipeline uses master.
interface tree_lane_scheduler_if
  import tree_lane_scheduler_pkg::*;
#(
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int NODE_WIDTH   = NODE_WIDTH_DEF,
  parameter int CNT_W        = 6
);

  logic [PACKET_WIDTH-1:0] in_packet_a;
  logic                    in_valid_a;
  logic [PACKET_WIDTH-1:0] in_packet_b;
  logic                    in_valid_b;
  logic                    in_ready;
  logic [NODE_WIDTH-1:0]   root_node;

  logic [PACKET_WIDTH-1:0] packet_out1;
  logic [PACKET_WIDTH-1:0] packet_out2;
  logic                    data_valid_out1;
  logic                    data_valid_out2;
  logic [NODE_WIDTH-1:0]   node_out1;
  logic [NODE_WIDTH-1:0]   node_out2;
  logic                    matched_out1;
  logic                    matched_out2;

  logic                    res_valid1;
  logic                    res_valid2;

  logic                    upd_req;
  logic                    upd_gnt;
  logic                    upd_done;
  logic [CNT_W-1:0]        inflight;
  logic                    err_underflow;

  modport slave (
    input  in_packet_a, in_valid_a, in_packet_b, in_valid_b, root_node,
    input  res_valid1, res_valid2, upd_req, upd_done,
    output in_ready, packet_out1, packet_out2, data_valid_out1, data_valid_out2,
    output node_out1, node_out2, matched_out1, matched_out2,
    output upd_gnt, inflight, err_underflow
  );

  modport master (
    output in_packet_a, in_valid_a, in_packet_b, in_valid_b, root_node,
    output res_valid1, res_valid2, upd_req, upd_done,
    input  in_ready, packet_out1, packet_out2, data_valid_out1, data_valid_out2,
    input  node_out1, node_out2, matched_out1, matched_out2,
    input  upd_gnt, inflight, err_underflow
  );

endinterface

// File: rtl/tree_lane_scheduler_inflight_counter.sv
// Outstanding-lookup counter: adds 0..2 issues and removes 0..2 completions
// in one update, clamping at both ends; underflow is sticky until reset.
module tree_lane_scheduler_inflight_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] count,
  output logic             err_underflow
);

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W+1:0] up_ext;
  logic [CNT_W+1:0] dec_ext;
  logic [CNT_W+1:0] diff;
  logic             under;

  assign up_ext  = {2'b00, count} + {{CNT_W{1'b0}}, inc};
  assign dec_ext = {{CNT_W{1'b0}}, dec};
  assign under   = up_ext < dec_ext;
  assign diff    = up_ext - dec_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (under) begin
        count         <= '0;
        err_underflow <= 1'b1;
      end else if (diff > CNT_MAX) begin
        count <= {CNT_W{1'b1}};
      end else begin
        count <= diff[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tree_lane_scheduler.sv
// Issues up to two headers per cycle into the tree root lanes, tracks
// outstanding lookups and grants node-memory updates only when drained.
module tree_lane_scheduler
  import tree_lane_scheduler_pkg::*;
#(
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int NODE_WIDTH   = NODE_WIDTH_DEF,
  parameter int MAX_INFLIGHT = 32,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input logic                  clk,
  input logic                  RST,
  tree_lane_scheduler_if.slave bus
);

  localparam logic [CNT_W+1:0] MAX_EXT = (CNT_W + 2)'(MAX_INFLIGHT);

  sch_state_t state, state_d;
  logic       rr, rr_d;
  logic       gnt;

  logic [CNT_W-1:0] inflight;
  logic             err_underflow;
  logic             room;
  logic             in_ready;
  logic             acc_a, acc_b;

  logic                    lane1_v_d, lane2_v_d;
  logic [PACKET_WIDTH-1:0] lane1_pkt_d, lane2_pkt_d;

  logic                    lane1_v, lane2_v;
  logic [PACKET_WIDTH-1:0] lane1_pkt, lane2_pkt;
  logic [NODE_WIDTH-1:0]   lane1_node, lane2_node;

  // Always reserve room for a full pair so acceptance never depends on slot count.
  assign room     = ({2'b00, inflight} + (CNT_W + 2)'(2)) <= MAX_EXT;
  assign in_ready = (state == SCH_RUN) && !bus.upd_req && room;
  assign acc_a    = in_ready && bus.in_valid_a;
  assign acc_b    = in_ready && bus.in_valid_b;

  always_comb begin
    lane1_v_d   = 1'b0;
    lane2_v_d   = 1'b0;
    lane1_pkt_d = '0;
    lane2_pkt_d = '0;
    rr_d        = rr;
    if (acc_a && acc_b) begin
      lane1_v_d   = 1'b1;
      lane1_pkt_d = bus.in_packet_a;
      lane2_v_d   = 1'b1;
      lane2_pkt_d = bus.in_packet_b;
    end else if (acc_a || acc_b) begin
      if (rr) begin
        lane2_v_d   = 1'b1;
        lane2_pkt_d = acc_a ? bus.in_packet_a : bus.in_packet_b;
      end else begin
        lane1_v_d   = 1'b1;
        lane1_pkt_d = acc_a ? bus.in_packet_a : bus.in_packet_b;
      end
      rr_d = !rr;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      SCH_RUN:    if (bus.upd_req) state_d = SCH_DRAIN;
      SCH_DRAIN: begin
        if (!bus.upd_req)
          state_d = SCH_RUN;
        else if (inflight == '0 && !bus.res_valid1 && !bus.res_valid2)
          state_d = SCH_UPDATE;
      end
      SCH_UPDATE: if (bus.upd_done) state_d = SCH_RUN;
      default:    state_d = SCH_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= SCH_RUN;
      rr    <= 1'b0;
      gnt   <= 1'b0;
    end else begin
      state <= state_d;
      rr    <= rr_d;
      gnt   <= (state_d == SCH_UPDATE);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      lane1_v    <= 1'b0;
      lane2_v    <= 1'b0;
      lane1_pkt  <= '0;
      lane2_pkt  <= '0;
      lane1_node <= '0;
      lane2_node <= '0;
    end else begin
      lane1_v    <= lane1_v_d;
      lane2_v    <= lane2_v_d;
      lane1_pkt  <= lane1_pkt_d;
      lane2_pkt  <= lane2_pkt_d;
      lane1_node <= lane1_v_d ? bus.root_node : '0;
      lane2_node <= lane2_v_d ? bus.root_node : '0;
    end
  end

  tree_lane_scheduler_inflight_counter #(.CNT_W(CNT_W)) u_inflight (
    .clk           (clk),
    .rst           (RST),
    .inc           (count2(acc_a, acc_b)),
    .dec           (count2(bus.res_valid1, bus.res_valid2)),
    .count         (inflight),
    .err_underflow (err_underflow)
  );

  assign bus.in_ready        = in_ready;
  assign bus.packet_out1     = lane1_pkt;
  assign bus.packet_out2     = lane2_pkt;
  assign bus.data_valid_out1 = lane1_v;
  assign bus.data_valid_out2 = lane2_v;
  assign bus.node_out1       = lane1_node;
  assign bus.node_out2       = lane2_node;
  assign bus.matched_out1    = 1'b0;
  assign bus.matched_out2    = 1'b0;
  assign bus.upd_gnt         = gnt;
  assign bus.inflight        = inflight;
  assign bus.err_underflow   = err_underflow;

endmodule

// File: tb/tb_tree_lane_scheduler.sv
// Directed bench for tree_lane_scheduler: a MAX_INFLIGHT=32 instance for
// issue/update/underflow behaviour and a MAX_INFLIGHT=4 instance for backpressure.
module tb_tree_lane_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  tree_lane_scheduler_if #(.PACKET_WIDTH(104), .NODE_WIDTH(40), .CNT_W(6)) bus  ();
  tree_lane_scheduler_if #(.PACKET_WIDTH(104), .NODE_WIDTH(40), .CNT_W(3)) bus4 ();

  tree_lane_scheduler #(.MAX_INFLIGHT(32)) dut  (.clk(clk), .RST(rst), .bus(bus.slave));
  tree_lane_scheduler #(.MAX_INFLIGHT(4))  dut4 (.clk(clk), .RST(rst), .bus(bus4.slave));

  task automatic idle_inputs();
    bus.in_packet_a  = '0; bus.in_valid_a  = 1'b0;
    bus.in_packet_b  = '0; bus.in_valid_b  = 1'b0;
    bus.root_node    = '0; bus.res_valid1  = 1'b0;
    bus.res_valid2   = 1'b0; bus.upd_req   = 1'b0;
    bus.upd_done     = 1'b0;
    bus4.in_packet_a = '0; bus4.in_valid_a = 1'b0;
    bus4.in_packet_b = '0; bus4.in_valid_b = 1'b0;
    bus4.root_node   = '0; bus4.res_valid1 = 1'b0;
    bus4.res_valid2  = 1'b0; bus4.upd_req  = 1'b0;
    bus4.upd_done    = 1'b0;
  endtask

  // Leaves the bench just after a negedge with reset released.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus.data_valid_out1 !== 1'b0 || bus.data_valid_out2 !== 1'b0)
      $display("FAIL reset_valids got=%b%b exp=00", bus.data_valid_out1, bus.data_valid_out2); else n_pass++;
    n_total++; if (bus.packet_out1 !== '0 || bus.node_out2 !== '0)
      $display("FAIL reset_lane_data got pkt1=%h node2=%h exp=0", bus.packet_out1, bus.node_out2); else n_pass++;
    n_total++; if (bus.upd_gnt !== 1'b0 || bus.err_underflow !== 1'b0)
      $display("FAIL reset_flags got gnt=%b err=%b exp=0", bus.upd_gnt, bus.err_underflow); else n_pass++;
    n_total++; if (bus.inflight !== 6'd0)
      $display("FAIL reset_inflight got=%0d exp=0", bus.inflight); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (bus.in_ready !== 1'b1)
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_dual_issue();
    do_reset();
    bus.in_packet_a = 104'h1; bus.in_valid_a = 1'b1;
    bus.in_packet_b = 104'h2; bus.in_valid_b = 1'b1;
    bus.root_node   = 40'hAB;
    #1;
    n_total++; if (bus.in_ready !== 1'b1)
      $display("FAIL dual_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.packet_out1 !== 104'h1 || bus.packet_out2 !== 104'h2)
      $display("FAIL dual_packets got=%h/%h exp=1/2", bus.packet_out1, bus.packet_out2); else n_pass++;
    n_total++; if (bus.data_valid_out1 !== 1'b1 || bus.data_valid_out2 !== 1'b1)
      $display("FAIL dual_valids got=%b%b exp=11", bus.data_valid_out1, bus.data_valid_out2); else n_pass++;
    n_total++; if (bus.node_out1 !== 40'hAB || bus.node_out2 !== 40'hAB)
      $display("FAIL dual_nodes got=%h/%h exp=ab/ab", bus.node_out1, bus.node_out2); else n_pass++;
    n_total++; if (bus.matched_out1 !== 1'b0 || bus.matched_out2 !== 1'b0)
      $display("FAIL dual_matched got=%b%b exp=00", bus.matched_out1, bus.matched_out2); else n_pass++;
    n_total++; if (bus.inflight !== 6'd2)
      $display("FAIL dual_inflight got=%0d exp=2", bus.inflight); else n_pass++;
    @(negedge clk);
    idle_inputs();
    bus.root_node = 40'hCD;
    @(posedge clk); #1;
    n_total++; if (bus.data_valid_out1 !== 1'b0 || bus.packet_out1 !== '0 || bus.node_out1 !== '0)
      $display("FAIL idle_lane_zero got v=%b pkt=%h node=%h exp=0", bus.data_valid_out1, bus.packet_out1, bus.node_out1); else n_pass++;
  endtask

  task automatic test_single_rr();
    logic [103:0] exp_pkt;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_pkt = 104'h10 + 104'(i);
      bus.in_packet_a = exp_pkt; bus.in_valid_a = 1'b1;
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        n_total++; if (bus.data_valid_out1 !== 1'b1 || bus.data_valid_out2 !== 1'b0 || bus.packet_out1 !== exp_pkt)
          $display("FAIL rr_lane1_%0d got v=%b%b pkt1=%h exp v=10 pkt1=%h", i, bus.data_valid_out1, bus.data_valid_out2, bus.packet_out1, exp_pkt); else n_pass++;
      end else begin
        n_total++; if (bus.data_valid_out1 !== 1'b0 || bus.data_valid_out2 !== 1'b1 || bus.packet_out2 !== exp_pkt)
          $display("FAIL rr_lane2_%0d got v=%b%b pkt2=%h exp v=01 pkt2=%h", i, bus.data_valid_out1, bus.data_valid_out2, bus.packet_out2, exp_pkt); else n_pass++;
      end
      @(negedge clk);
    end
    idle_inputs();
    n_total++; if (bus.inflight !== 6'd3)
      $display("FAIL rr_inflight got=%0d exp=3", bus.inflight); else n_pass++;
    // rr is now 1, so a lone B-slot header lands on lane 2.
    bus.in_packet_b = 104'h20; bus.in_valid_b = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus.data_valid_out2 !== 1'b1 || bus.data_valid_out1 !== 1'b0 || bus.packet_out2 !== 104'h20)
      $display("FAIL rr_b_only got v=%b%b pkt2=%h exp v=01 pkt2=20", bus.data_valid_out1, bus.data_valid_out2, bus.packet_out2); else n_pass++;
    n_total++; if (bus.inflight !== 6'd4)
      $display("FAIL rr_b_inflight got=%0d exp=4", bus.inflight); else n_pass++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus4.in_valid_a = 1'b1; bus4.in_valid_b = 1'b1;
    bus4.in_packet_a = 104'h31; bus4.in_packet_b = 104'h32;
    @(posedge clk); #1;
    @(negedge clk); #1;
    n_total++; if (bus4.in_ready !== 1'b1)
      $display("FAIL bp_ready_at2 got=%b exp=1", bus4.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus4.inflight !== 3'd4)
      $display("FAIL bp_inflight4 got=%0d exp=4", bus4.inflight); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (bus4.in_ready !== 1'b0)
      $display("FAIL bp_ready_full got=%b exp=0", bus4.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus4.data_valid_out1 !== 1'b0 || bus4.inflight !== 3'd4)
      $display("FAIL bp_no_accept got v1=%b inflight=%0d exp v1=0 inflight=4", bus4.data_valid_out1, bus4.inflight); else n_pass++;
    @(negedge clk);
    bus4.res_valid1 = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus4.inflight !== 3'd3)
      $display("FAIL bp_inflight3 got=%0d exp=3", bus4.inflight); else n_pass++;
    @(negedge clk);
    bus4.res_valid1 = 1'b0; bus4.in_valid_a = 1'b0; bus4.in_valid_b = 1'b0;
    #1;
    n_total++; if (bus4.in_ready !== 1'b0)
      $display("FAIL bp_ready_at3 got=%b exp=0", bus4.in_ready); else n_pass++;
    bus4.res_valid2 = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus4.inflight !== 3'd2)
      $display("FAIL bp_inflight2 got=%0d exp=2", bus4.inflight); else n_pass++;
    @(negedge clk);
    bus4.res_valid2 = 1'b0;
    #1;
    n_total++; if (bus4.in_ready !== 1'b1)
      $display("FAIL bp_ready_reopen got=%b exp=1", bus4.in_ready); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_update();
    do_reset();
    bus.in_valid_a = 1'b1; bus.in_valid_b = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.upd_req = 1'b1;
    #1;
    n_total++; if (bus.in_ready !== 1'b0)
      $display("FAIL upd_ready_same_cycle got=%b exp=0", bus.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.data_valid_out1 !== 1'b0 || bus.inflight !== 6'd2 || bus.upd_gnt !== 1'b0)
      $display("FAIL upd_drain_entry got v1=%b inflight=%0d gnt=%b exp 0/2/0", bus.data_valid_out1, bus.inflight, bus.upd_gnt); else n_pass++;
    @(negedge clk);
    bus.in_valid_a = 1'b0; bus.in_valid_b = 1'b0;
    bus.res_valid1 = 1'b1; bus.res_valid2 = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus.inflight !== 6'd0 || bus.upd_gnt !== 1'b0)
      $display("FAIL upd_drained got inflight=%0d gnt=%b exp 0/0", bus.inflight, bus.upd_gnt); else n_pass++;
    @(negedge clk);
    bus.res_valid1 = 1'b0; bus.res_valid2 = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.upd_gnt !== 1'b1)
      $display("FAIL upd_gnt_high got=%b exp=1", bus.upd_gnt); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.upd_gnt !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL upd_gnt_hold got gnt=%b ready=%b exp 1/0", bus.upd_gnt, bus.in_ready); else n_pass++;
    @(negedge clk);
    bus.upd_done = 1'b1; bus.upd_req = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.upd_gnt !== 1'b0)
      $display("FAIL upd_gnt_release got=%b exp=0", bus.upd_gnt); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (bus.in_ready !== 1'b1)
      $display("FAIL upd_back_to_run got ready=%b exp=1", bus.in_ready); else n_pass++;
    // upd_done pulse while already in RUN must not disturb anything.
    @(posedge clk); #1;
    bus.upd_done = 1'b0;
    @(negedge clk);
    #1;
    n_total++; if (bus.upd_gnt !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL upd_done_ignored got gnt=%b ready=%b exp 0/1", bus.upd_gnt, bus.in_ready); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_drain_abort();
    do_reset();
    bus.in_valid_a = 1'b1; bus.in_valid_b = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.in_valid_a = 1'b0; bus.in_valid_b = 1'b0;
    bus.upd_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.upd_req = 1'b0;
    #1;
    n_total++; if (bus.in_ready !== 1'b0)
      $display("FAIL abort_still_drain got ready=%b exp=0", bus.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.in_ready !== 1'b1 || bus.upd_gnt !== 1'b0 || bus.inflight !== 6'd2)
      $display("FAIL abort_run got ready=%b gnt=%b inflight=%0d exp 1/0/2", bus.in_ready, bus.upd_gnt, bus.inflight); else n_pass++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back_net();
    do_reset();
    bus.in_valid_a = 1'b1; bus.in_valid_b = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.in_valid_b = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.inflight !== 6'd5)
      $display("FAIL net_setup got=%0d exp=5", bus.inflight); else n_pass++;
    @(negedge clk);
    bus.in_valid_b = 1'b1;
    bus.res_valid1 = 1'b1; bus.res_valid2 = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus.inflight !== 6'd5 || bus.data_valid_out1 !== 1'b1 || bus.data_valid_out2 !== 1'b1)
      $display("FAIL net_same_cycle got inflight=%0d v=%b%b exp 5/11", bus.inflight, bus.data_valid_out1, bus.data_valid_out2); else n_pass++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_underflow();
    do_reset();
    bus.res_valid1 = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus.inflight !== 6'd0 || bus.err_underflow !== 1'b1)
      $display("FAIL uf_set got inflight=%0d err=%b exp 0/1", bus.inflight, bus.err_underflow); else n_pass++;
    @(negedge clk);
    bus.res_valid1 = 1'b0;
    bus.in_valid_a = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus.err_underflow !== 1'b1 || bus.inflight !== 6'd1)
      $display("FAIL uf_sticky got err=%b inflight=%0d exp 1/1", bus.err_underflow, bus.inflight); else n_pass++;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus.err_underflow !== 1'b0 || bus.inflight !== 6'd0)
      $display("FAIL uf_cleared got err=%b inflight=%0d exp 0/0", bus.err_underflow, bus.inflight); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_dual_issue();
    test_single_rr();
    test_backpressure();
    test_update();
    test_drain_abort();
    test_back_to_back_net();
    test_underflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tree_lane_scheduler.md
Name: tree_lane_scheduler

Overview:
- Front-end controller for the two-lane decision-tree lookup pipeline.
- Accepts up to two packet headers per cycle and issues them into lane 1 and lane 2 at the tree root.
- Tracks in-flight lookups by counting result valids returned from the final level.
- Runs a drain/grant handshake so node memories can be reconfigured only while the pipeline is empty.

Parameters:
PACKET_WIDTH, 104, packet header width
NODE_WIDTH, 40, tree node word width
MAX_INFLIGHT, 32, maximum lookups outstanding across both lanes (≥2)
CNT_W, $clog2(MAX_INFLIGHT+1), in-flight counter width (derived)

Ports:
clk  in  1  clock
RST  in  1  synchronous reset, active-high
in_packet_a  in  PACKET_WIDTH  ingress header slot A
in_valid_a  in  1  slot A valid
in_packet_b  in  PACKET_WIDTH  ingress header slot B
in_valid_b  in  1  slot B valid
in_ready  out  1  both slots accepted this cycle when high
root_node  in  NODE_WIDTH  root node word driven into both lanes
packet_out1 / packet_out2  out  PACKET_WIDTH  lane headers to level 1
data_valid_out1 / data_valid_out2  out  1  lane valids
node_out1 / node_out2  out  NODE_WIDTH  lane node words
matched_out1 / matched_out2  out  1  lane matched flags, always 0 on issue
res_valid1 / res_valid2  in  1  final-level lane valids (completions)
upd_req  in  1  reconfiguration request, level
upd_gnt  out  1  pipeline empty; reconfiguration allowed
upd_done  in  1  one-cycle pulse ending reconfiguration
inflight  out  CNT_W  current outstanding count
err_underflow  out  1  sticky flag: completion seen with inflight==0

Behaviour:
- Reset, sampled on clk while RST=1: all lane outputs 0, upd_gnt=0, inflight=0, err_underflow=0, rr=0, state=RUN.
- FSM states:
  - RUN: issue allowed.
  - DRAIN: no issue; wait for empty.
  - UPDATE: upd_gnt=1.
- FSM transitions:
  - RUN→DRAIN when upd_req=1.
  - DRAIN→UPDATE when inflight==0 and no completions this cycle.
  - DRAIN→RUN if upd_req drops before the grant.
  - UPDATE→RUN on upd_done.
  - upd_done outside UPDATE is ignored.
- in_ready is combinational: state==RUN && !upd_req && inflight+2 ≤ MAX_INFLIGHT. It goes low in the same cycle upd_req rises.
- Acceptance: a slot is accepted when in_ready && its valid. Accepted headers appear on lane outputs the next cycle (latency 1). Lane outputs are registered.
- Lane assignment:
  - Both slots valid: A→lane1, B→lane2; rr unchanged.
  - Exactly one slot valid: it goes to lane (rr ? 2 : 1), then rr toggles.
- A lane with nothing issued drives data_valid=0, with packet and node zeroed.
- node_outN = root_node sampled at acceptance.
- inflight_next = inflight + issued − (res_valid1 + res_valid2). issued and completions are each 0..2, and simultaneous events net out in one update.
- Underflow: a decrement that would go below 0 saturates at 0 and sets err_underflow. err_underflow clears only on RST.
- upd_gnt is registered: asserted the cycle after entering UPDATE, deasserted the cycle after upd_done.
- Reset mid-DRAIN or mid-UPDATE: returns to RUN with upd_gnt=0 and inflight=0. Upstream must flush the pipeline registers on the same reset.

Decomposition:
- Shared package holds:
  - state encoding (SCH_RUN=2'd0, SCH_DRAIN=2'd1, SCH_UPDATE=2'd2);
  - PACKET_WIDTH and NODE_WIDTH defaults, shared with the level pipeline registers.
- Sub-module inflight_counter (CNT_W, saturating ±2 up/down with underflow flag).
- Issue logic and FSM stay in the top module.

Test Plan:
- Reset → all outputs 0, in_ready=1. Then in_valid_a=in_valid_b=1 with A=0x1, B=0x2 → next cycle packet_out1=0x1, packet_out2=0x2, both valids=1, inflight=2.
- Three cycles of A-only valid, no completions → lanes 1, 2, 1 in order; inflight=3; rr=1.
- MAX_INFLIGHT=4: issue 2+2 → in_ready=0. Then res_valid1=1 for one cycle → inflight=3, in_ready still 0. Then res_valid2=1 → inflight=2, in_ready=1.
- inflight=2, assert upd_req → in_ready=0 in the same cycle; state=DRAIN. Completions on both lanes → UPDATE, upd_gnt=1. upd_done pulse → upd_gnt=0, RUN, in_ready=1.
- In the same cycle, issue 2 and res_valid1=res_valid2=1 with inflight=5 → inflight stays 5.
- inflight=0 with res_valid1=1 → inflight=0, err_underflow=1 and held. Then RST=1 for one cycle → err_underflow=0.
